four_bit_seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider. It is the inverse of the team's ripple-carry adder path: repeated subtract-and-shift instead of add.
- Each iteration uses an internal (WIDTH+1)-bit ripple-borrow subtractor, built as a full-adder chain on the complemented divisor with carry-in 1.
- Sits beside the adder datapath.
- Operands are presented with a Start pulse. Quotient and remainder return with a one-cycle Done pulse after a fixed latency.

---
 rtl/four_bit_seq_divider.sv | 103 ++++++++++
 tb/tb_four_bit_seq_divider.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/four_bit_seq_divider.sv
// four_bit_seq_divider: multi-cycle unsigned restoring divider.
// Each RUN cycle does one trial subtraction through a ripple-borrow full-adder chain.
module four_bit_seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [0:WIDTH-1] Dividend,
    input  logic [0:WIDTH-1] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [0:WIDTH-1] Quotient,
    output logic [0:WIDTH-1] Remainder,
    output logic             DivZero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d, d_q, d_d, quo_q, quo_d, rem_q, rem_d;
    logic [WIDTH-1:0] dvd, dvs;
    logic [WIDTH:0]   p_q, p_d, t, b, diff;
    logic [WIDTH+1:0] c;
    logic             dz_q, dz_d;

    // Ports number bit 0 as the LSB; map them onto conventional descending vectors.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bits
        assign dvd[i]       = Dividend[i];
        assign dvs[i]       = Divisor[i];
        assign Quotient[i]  = quo_q[i];
        assign Remainder[i] = rem_q[i];
    end

    // The top bit of P is always 0 (P < D), so shifting it out loses nothing.
    assign t    = (WIDTH + 1)'({p_q, q_q[WIDTH-1]});
    assign b    = ~{1'b0, d_q};
    assign c[0] = 1'b1;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
        assign diff[i]  = t[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (t[i] & b[i]) | (c[i] & (t[i] ^ b[i]));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        d_d     = d_q;
        p_d     = p_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        if (state_q == RUN) begin
            if (cnt_q == CW'(WIDTH)) begin
                state_d = DONE;
                quo_d   = q_q;
                rem_d   = p_q[WIDTH-1:0];
            end else begin
                p_d   = c[WIDTH+1] ? diff : t;
                q_d   = {q_q[WIDTH-2:0], c[WIDTH+1]};
                cnt_d = cnt_q + 1'b1;
            end
        end else if (Start) begin
            state_d = RUN;
            q_d     = dvd;
            d_d     = dvs;
            p_d     = '0;
            dz_d    = (dvs == '0);
            cnt_d   = '0;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            d_q     <= '0;
            p_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            d_q     <= d_d;
            p_q     <= p_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign Busy    = (state_q == RUN);
    assign Done    = (state_q == DONE);
    assign DivZero = dz_q;
endmodule

// File: tb/tb_four_bit_seq_divider.sv
// tb_four_bit_seq_divider: scoreboard bench; expected results come from plain integer division.
module tb_four_bit_seq_divider;
    localparam int W = 4;

    logic         Clk = 1'b0;
    logic         Rst, Start, Busy, Done, DivZero;
    logic [0:W-1] Dividend, Divisor, Quotient, Remainder;

    four_bit_seq_divider #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Dividend(Dividend), .Divisor(Divisor),
        .Busy(Busy), .Done(Done), .Quotient(Quotient), .Remainder(Remainder), .DivZero(DivZero)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [W-1:0] val(input logic [0:W-1] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic drive(input int a, input int b);
        logic [W-1:0] av, bv;
        av = W'(a);
        bv = W'(b);
        for (int i = 0; i < W; i++) begin
            Dividend[i] = av[i];
            Divisor[i]  = bv[i];
        end
    endtask

    // Called 1 time unit after an edge; the operation is accepted on the next edge.
    task automatic issue(input int a, input int b);
        exp_t e;
        drive(a, b);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        e.q   = (b == 0) ? '1 : W'(a / b);
        e.r   = (b == 0) ? W'(a) : W'(a % b);
        e.dz  = (b == 0);
        e.acc = cyc;
        sb.push_back(e);
        drive(int'($urandom), int'($urandom));
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && sb.size() > 0; k++) begin
            @(posedge Clk);
            #1;
        end
        if (sb.size() > 0) chk("drain", sb.size(), 0);
    endtask

    // Leaves the bench inside the Done cycle of the oldest pending operation.
    task automatic to_done();
        for (int k = 0; k < 20 && sb.size() > 0 && cyc < sb[0].acc + 5; k++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic next_op(input int a, input int b);
        if (sb.size() > 0) begin
            if ($urandom_range(1, 0) == 1) to_done();
            else begin
                wait_idle();
                repeat ($urandom_range(2, 0)) begin
                    @(posedge Clk);
                    #1;
                end
            end
        end
        issue(a, b);
    endtask

    always @(negedge Clk) begin : monitor
        exp_t e;
        if (!Rst) begin
            if (sb.size() > 0) chk("busy", int'(Busy), int'(cyc >= sb[0].acc && cyc < sb[0].acc + 5));
            else chk("busy_idle", int'(Busy), 0);
            if (Done) begin
                if (sb.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("done_latency", cyc, e.acc + 5);
                    chk("quotient", int'(val(Quotient)), int'(e.q));
                    chk("remainder", int'(val(Remainder)), int'(e.r));
                    chk("divzero", int'(DivZero), int'(e.dz));
                end
            end else if (sb.size() > 0 && cyc >= sb[0].acc + 5) begin
                chk("done_timeout", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Rst   = 1'b1;
        Start = 1'b0;
        drive(0, 0);
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_quotient", int'(val(Quotient)), 0);
        chk("rst_remainder", int'(val(Remainder)), 0);
        chk("rst_divzero", int'(DivZero), 0);

        issue(13, 4);
        wait_idle();

        issue(15, 1);
        to_done();
        issue(6, 3);
        wait_idle();

        issue(5, 0);
        wait_idle();

        issue(3, 7);
        wait_idle();
        repeat (10) begin
            @(posedge Clk);
            #1;
            chk("hold_quotient", int'(val(Quotient)), 0);
            chk("hold_remainder", int'(val(Remainder)), 3);
            chk("hold_done", int'(Done), 0);
        end

        issue(9, 2);
        @(posedge Clk);
        #1;
        drive(14, 7);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        drive(int'($urandom), int'($urandom));
        wait_idle();

        issue(12, 5);
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        sb.delete();
        chk("abort_busy", int'(Busy), 0);
        chk("abort_done", int'(Done), 0);
        chk("abort_quotient", int'(val(Quotient)), 0);
        chk("abort_remainder", int'(val(Remainder)), 0);
        chk("abort_divzero", int'(DivZero), 0);
        repeat (8) begin
            @(posedge Clk);
            #1;
        end

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) next_op(a, b);
        for (int n = 0; n < 100; n++) next_op(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
        wait_idle();
        repeat (3) @(posedge Clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
